// File: rtl/sonar_sweep_ctrl.sv
// Sonar sweep controller: steps a servo through positions 0..7 in a
// triangle pattern, waits for the servo to settle, triggers a distance
// measurement, hands the record to a serial transmitter, then advances.
//
// Ports
//   clock          system clock, rising edge
//   reset          asynchronous, active-high reset
//   ligar          sweep enable (level)
//   sensor_pronto  distance sensor done (pulse or level)
//   tx_pronto      record transmitter done
//   posicao[2:0]   current servo position index
//   sentido        sweep direction, 1 = ascending
//   medir          one-cycle measurement start pulse
//   tx_iniciar     one-cycle record transmission start pulse
//   erro_medida    record in flight comes from a timed-out measurement
//   db_estado[3:0] current state code
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | sweep disabled, position parked at 0 ascending
// POSICIONA  | waiting SETTLE_CYCLES for the servo to settle
// MEDE       | medir pulse
// ESPERA_MED | waiting for sensor_pronto or TIMEOUT_CYCLES
// TRANSMITE  | tx_iniciar pulse
// ESPERA_TX  | waiting for tx_pronto
// AVANCA     | step position along the triangle sweep

module sonar_sweep_ctrl #(
   parameter int unsigned SETTLE_CYCLES  = 25000000,
   parameter int unsigned TIMEOUT_CYCLES = 3000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       ligar,
   input  logic       sensor_pronto,
   input  logic       tx_pronto,
   output logic [2:0] posicao,
   output logic       sentido,
   output logic       medir,
   output logic       tx_iniciar,
   output logic       erro_medida,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      POSICIONA  = 4'd1,
      MEDE       = 4'd2,
      ESPERA_MED = 4'd3,
      TRANSMITE  = 4'd4,
      ESPERA_TX  = 4'd5,
      AVANCA     = 4'd6
   } estado_t;

   // The timer counts up from 0 on state entry, so the last cycle of a
   // wait of N cycles is the one where the timer reads N-1.
   localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

   estado_t     r_estado;
   logic [31:0] r_timer;
   logic [2:0]  r_posicao;
   logic        r_sentido;
   logic        r_medir;
   logic        r_tx_iniciar;
   logic        r_erro;
   logic [31:0] w_timer_inc;

   // Saturating increment: the timer must never wrap back to zero.
   assign w_timer_inc = (r_timer == 32'hFFFF_FFFF) ? r_timer : r_timer + 32'd1;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_estado     <= IDLE;
         r_timer      <= 32'd0;
         r_posicao    <= 3'd0;
         r_sentido    <= 1'b1;
         r_medir      <= 1'b0;
         r_tx_iniciar <= 1'b0;
         r_erro       <= 1'b0;
      end else begin
         r_medir      <= 1'b0;
         r_tx_iniciar <= 1'b0;
         // Disable wins over every state transition, including the ones
         // that would otherwise raise a pulse on this clock.
         if (!ligar && r_estado != IDLE) begin
            r_estado  <= IDLE;
            r_timer   <= 32'd0;
            r_posicao <= 3'd0;
            r_sentido <= 1'b1;
            r_erro    <= 1'b0;
         end else begin
            case (r_estado)
               IDLE: begin
                  if (ligar) begin
                     r_estado <= POSICIONA;
                     r_timer  <= 32'd0;
                  end
               end
               POSICIONA: begin
                  if (r_timer >= SETTLE_LAST) begin
                     r_estado <= MEDE;
                     r_medir  <= 1'b1;
                  end else begin
                     r_timer <= w_timer_inc;
                  end
               end
               MEDE: begin
                  r_estado <= ESPERA_MED;
                  r_timer  <= 32'd0;
               end
               ESPERA_MED: begin
                  // A sensor answer on the timeout cycle still counts as valid.
                  if (sensor_pronto) begin
                     r_estado     <= TRANSMITE;
                     r_tx_iniciar <= 1'b1;
                     r_erro       <= 1'b0;
                  end else if (r_timer >= TIMEOUT_LAST) begin
                     r_estado     <= TRANSMITE;
                     r_tx_iniciar <= 1'b1;
                     r_erro       <= 1'b1;
                  end else begin
                     r_timer <= w_timer_inc;
                  end
               end
               TRANSMITE: begin
                  r_estado <= ESPERA_TX;
               end
               ESPERA_TX: begin
                  if (tx_pronto) begin
                     r_estado <= AVANCA;
                     r_erro   <= 1'b0;
                  end
               end
               AVANCA: begin
                  r_estado <= POSICIONA;
                  r_timer  <= 32'd0;
                  if (r_sentido) begin
                     if (r_posicao == 3'd7) begin
                        r_posicao <= 3'd6;
                        r_sentido <= 1'b0;
                     end else begin
                        r_posicao <= r_posicao + 3'd1;
                     end
                  end else begin
                     if (r_posicao == 3'd0) begin
                        r_posicao <= 3'd1;
                        r_sentido <= 1'b1;
                     end else begin
                        r_posicao <= r_posicao - 3'd1;
                     end
                  end
               end
               default: begin
                  r_estado <= IDLE;
               end
            endcase
         end
      end
   end

   assign posicao     = r_posicao;
   assign sentido     = r_sentido;
   assign medir       = r_medir;
   assign tx_iniciar  = r_tx_iniciar;
   assign erro_medida = r_erro;
   assign db_estado   = r_estado;

endmodule

// File: tb/tb_sonar_sweep_ctrl.sv
module tb_sonar_sweep_ctrl;

   localparam int S = 4;
   localparam int T = 10;

   logic       clock;
   logic       reset;
   logic       ligar;
   logic       sensor_pronto;
   logic       tx_pronto;
   logic [2:0] posicao;
   logic       sentido;
   logic       medir;
   logic       tx_iniciar;
   logic       erro_medida;
   logic [3:0] db_estado;

   sonar_sweep_ctrl #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
      .clock(clock),
      .reset(reset),
      .ligar(ligar),
      .sensor_pronto(sensor_pronto),
      .tx_pronto(tx_pronto),
      .posicao(posicao),
      .sentido(sentido),
      .medir(medir),
      .tx_iniciar(tx_iniciar),
      .erro_medida(erro_medida),
      .db_estado(db_estado)
   );

   typedef struct {
      int kind;   // 0 = medir pulse, 1 = tx_iniciar pulse
      int cyc;
      int pos;
      int sent;
      int err;
   } ev_t;

   ev_t q_exp[$];
   bit  sens_sched[int];
   bit  tx_sched[int];
   int  force_d[int];
   int  force_e[int];
   bit  sens_hold;
   bit  tx_hold;
   int  cyc;
   int  n_checks;
   int  n_errors;
   int  last_err;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge clock);
         #1;
      end
   endtask

   // Reference model: walks the sweep as a list of steps. Step i measures at
   // the i-th point of the triangle 0..7..0; timing follows from the settle
   // time, sensor delay d (0 = never answers) and transmitter delay e.
   // last_mode: 0 full step, 1 stop in ESPERA_TX, 2 stop at the medir pulse.
   task automatic plan(input int p, input int nsteps, input int last_mode, output int t_end);
      int entry, m, t, d, e, r, pos, sent, err;
      ev_t ev;
      entry = p + 1;
      t_end = 0;
      for (int i = 0; i < nsteps; i++) begin
         r    = i % 14;
         pos  = (r <= 7) ? r : 14 - r;
         sent = (i == 0 || (r >= 1 && r <= 7)) ? 1 : 0;
         m    = entry + S;
         if (i == nsteps - 1 && last_mode == 2) begin
            sens_sched[m + 2] = 1'b1;
            t_end = m;
         end else begin
            if (force_d.exists(i)) d = force_d[i];
            else if ($urandom_range(7, 0) == 0) d = 0;
            else d = int'($urandom_range(12, 1));
            e = force_e.exists(i) ? force_e[i] : int'($urandom_range(6, 1));
            ev.kind = 0; ev.cyc = m; ev.pos = pos; ev.sent = sent; ev.err = 0;
            q_exp.push_back(ev);
            if (d >= 1 && d <= T) begin
               t = m + d + 1;
               err = 0;
            end else begin
               t = m + 1 + T;
               err = 1;
            end
            if (d != 0) sens_sched[m + d] = 1'b1;
            ev.kind = 1; ev.cyc = t; ev.err = err;
            q_exp.push_back(ev);
            t_end = t;
            last_err = err;
            if (!(i == nsteps - 1 && last_mode == 1)) begin
               tx_sched[t + e] = 1'b1;
               entry = t + e + 2;
            end
         end
      end
      force_d.delete();
      force_e.delete();
   endtask

   // Sensor / transmitter responder, driven from the model's schedule.
   initial begin
      sensor_pronto = 1'b0;
      tx_pronto     = 1'b0;
      forever begin
         @(posedge clock);
         #2;
         sensor_pronto = sens_hold || sens_sched.exists(cyc);
         tx_pronto     = tx_hold || tx_sched.exists(cyc);
      end
   end

   // Monitor: every pulse the DUT presents is matched against the scoreboard.
   initial begin
      ev_t ev;
      forever begin
         @(negedge clock);
         if (medir || tx_iniciar) begin
            if (medir && tx_iniciar) begin
               chk("medir_and_tx_together", 1, 0);
            end else if (q_exp.size() == 0) begin
               chk(medir ? "unexpected_medir" : "unexpected_tx_iniciar", 1, 0);
            end else begin
               ev = q_exp.pop_front();
               chk($sformatf("kind@%0d", ev.cyc), int'(tx_iniciar), ev.kind);
               chk($sformatf("cycle_k%0d", ev.kind), cyc, ev.cyc);
               chk($sformatf("posicao@%0d", ev.cyc), int'(posicao), ev.pos);
               chk($sformatf("sentido@%0d", ev.cyc), int'(sentido), ev.sent);
               chk($sformatf("erro_medida@%0d", ev.cyc), int'(erro_medida), ev.err);
            end
         end
      end
   end

   task automatic check_idle(input string tag);
      chk({tag, "_db_estado"}, int'(db_estado), 0);
      chk({tag, "_posicao"}, int'(posicao), 0);
      chk({tag, "_sentido"}, int'(sentido), 1);
      chk({tag, "_erro"}, int'(erro_medida), 0);
      chk({tag, "_medir"}, int'(medir), 0);
      chk({tag, "_tx"}, int'(tx_iniciar), 0);
   endtask

   initial begin
      int p, t_end, m;
      n_checks  = 0;
      n_errors  = 0;
      last_err  = 0;
      sens_hold = 1'b0;
      tx_hold   = 1'b0;
      reset     = 1'b1;
      ligar     = 1'b0;

      goto(2);
      check_idle("reset");
      reset = 1'b0;

      // Normal first step, then a full triangle sweep with random delays.
      goto(cyc + 2);
      p = cyc;
      ligar = 1'b1;
      force_d[0] = 3;
      force_e[0] = 5;
      plan(p, 17, 1, t_end);
      goto(t_end + 2);
      ligar = 1'b0;
      goto(t_end + 3);
      check_idle("disable_a");
      chk("queue_empty_a", q_exp.size(), 0);

      // Timeout boundaries, then disable in ESPERA_TX at position 5 descending.
      goto(cyc + 3);
      p = cyc;
      ligar = 1'b1;
      force_d[0] = 0;
      force_d[1] = 10;
      force_d[2] = 11;
      force_d[3] = 1;
      force_d[9] = 0;
      plan(p, 10, 1, t_end);
      goto(t_end + 2);
      chk("espera_tx_db_estado", int'(db_estado), 5);
      chk("espera_tx_erro_hold", int'(erro_medida), 1);
      chk("espera_tx_posicao", int'(posicao), 5);
      chk("espera_tx_sentido", int'(sentido), 0);
      ligar = 1'b0;
      goto(t_end + 3);
      check_idle("disable_b");
      chk("queue_empty_b", q_exp.size(), 0);

      // Restart from position 0, then an async reset in the middle of MEDE.
      goto(cyc + 4);
      p = cyc;
      ligar = 1'b1;
      plan(p, 3, 2, m);
      goto(m);
      chk("mede_medir_high", int'(medir), 1);
      chk("mede_posicao", int'(posicao), 2);
      chk("mede_db_estado", int'(db_estado), 2);
      #2;
      reset = 1'b1;
      ligar = 1'b0;
      #1;
      check_idle("async_reset");
      goto(m + 2);
      reset = 1'b0;
      goto(m + 40);
      chk("after_reset_db_estado", int'(db_estado), 0);
      chk("queue_empty_c", q_exp.size(), 0);

      // Spurious sensor_pronto/tx_pronto held high through IDLE and POSICIONA.
      goto(cyc + 2);
      sens_hold = 1'b1;
      tx_hold   = 1'b1;
      goto(cyc + 3);
      p = cyc;
      ligar = 1'b1;
      force_d[0] = 2;
      plan(p, 2, 1, t_end);
      goto(p + 3);
      chk("spurious_db_estado", int'(db_estado), 1);
      goto(p + 4);
      sens_hold = 1'b0;
      tx_hold   = 1'b0;
      goto(t_end + 2);
      ligar = 1'b0;
      goto(t_end + 3);
      check_idle("disable_d");
      goto(cyc + 10);
      chk("queue_empty_d", q_exp.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sonar_sweep_ctrl.md
SONAR_SWEEP_CTRL -- requirements
Module: sonar_sweep_ctrl

Interface
REQ-001 Parameter SETTLE_CYCLES, default 25000000, meaning servo settling time in clock cycles per position (>=1).
REQ-002 Parameter TIMEOUT_CYCLES, default 3000000, meaning maximum wait for sensor_pronto after a measure request (>=1).
REQ-003 clock  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ligar  input  1  sweep enable; level, synchronous.
REQ-006 sensor_pronto  input  1  distance sensor measurement done; single-cycle pulse or level.
REQ-007 tx_pronto  input  1  serial record transmitter finished the current record.
REQ-008 posicao  output  3  current servo position index 0..7; registered.
REQ-009 sentido  output  1  sweep direction; 1 = ascending, 0 = descending.
REQ-010 medir  output  1  one-cycle pulse starting a distance measurement.
REQ-011 tx_iniciar  output  1  one-cycle pulse starting transmission of the position/distance record.
REQ-012 erro_medida  output  1  high while the record being transmitted comes from a timed-out measurement.
REQ-013 db_estado  output  4  current state code, combinational from the state register.

Function
REQ-014 States and codes: IDLE=0, POSICIONA=1, MEDE=2, ESPERA_MED=3, TRANSMITE=4, ESPERA_TX=5, AVANCA=6; codes 7-15 are unused and SHALL go to IDLE on the next clock.
REQ-015 IDLE: stay while ligar=0; ligar=1 -> POSICIONA.
REQ-016 POSICIONA: a 32-bit cycle timer SHALL clear on entry; the FSM SHALL stay exactly SETTLE_CYCLES cycles and then go to MEDE.
REQ-017 MEDE: lasts one cycle with medir=1, then ESPERA_MED; medir=0 in every other state.
REQ-018 ESPERA_MED: the timer SHALL clear on entry.
- sensor_pronto=1 -> TRANSMITE with erro_medida flag cleared.
- Timer reaching TIMEOUT_CYCLES without sensor_pronto -> TRANSMITE with erro_medida flag set.
- sensor_pronto on the timeout cycle wins: flag cleared.
REQ-019 TRANSMITE: lasts one cycle with tx_iniciar=1, then ESPERA_TX.
REQ-020 ESPERA_TX: stay until tx_pronto=1, then AVANCA; no timeout.
- tx_pronto in any other state SHALL be ignored.
REQ-021 erro_medida SHALL be asserted from TRANSMITE through ESPERA_TX when the flag is set, and 0 elsewhere.
REQ-022 AVANCA: one cycle, then POSICIONA, with the triangle sweep 0,1,...,7,6,...,0,1,... applied as follows.
- sentido=1 and posicao<7: posicao+1.
- sentido=1 and posicao=7: posicao=6, sentido=0.
- sentido=0 and posicao>0: posicao-1.
- sentido=0 and posicao=0: posicao=1, sentido=1.
REQ-023 posicao and sentido SHALL change only in AVANCA, on reset, or on disable.
REQ-024 Disable: ligar=0 sampled in any non-IDLE state SHALL move to IDLE on the next clock.
- On that clock: posicao=0, sentido=1, timer cleared, flag cleared.
- No medir or tx_iniciar pulse SHALL be produced on that clock.
REQ-025 A sweep restarted after disable SHALL begin at position 0 ascending with a full SETTLE_CYCLES wait.
REQ-026 Timer SHALL saturate, not wrap, and SHALL hold in states that do not use it.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, posicao=0, sentido=1, medir=0, tx_iniciar=0, erro_medida=0, timer=0, db_estado=0.
REQ-028 Reset asserted mid-sweep SHALL abandon any pending measurement or transmission; no pulse SHALL follow reset release until the path through POSICIONA is taken again.

Verification (SETTLE_CYCLES=4, TIMEOUT_CYCLES=10)
REQ-029 Normal cycle:
- Stimulus: ligar=1; sensor_pronto 3 cycles after medir; tx_pronto 5 cycles after tx_iniciar.
- Required: medir exactly 5 cycles after leaving IDLE (1 transition + 4 settle), then tx_iniciar one cycle after sensor_pronto, erro_medida=0, posicao 0->1 after AVANCA.
REQ-030 Full sweep, responsive sensor/tx: posicao sequence 0,1,2,3,4,5,6,7,6,5,4,3,2,1,0,1; sentido falls at 7->6 and rises at 0->1.
REQ-031 Timeout: sensor_pronto never asserted -> tx_iniciar 10 cycles after entering ESPERA_MED, erro_medida=1 until AVANCA; sensor_pronto on the 10th cycle -> erro_medida=0.
REQ-032 Disable mid-ESPERA_TX at posicao=5 descending: ligar=0 -> next clock IDLE, posicao=0, sentido=1; ligar=1 again -> first medir at posicao=0 after full settle.
REQ-033 Async reset pulse between clock edges during MEDE: medir drops immediately, db_estado=0, no tx_iniciar ever follows.
REQ-034 Spurious tx_pronto and sensor_pronto held high in IDLE and POSICIONA: no state skip, settle count unchanged.
